// File: rtl/ring_pkg.sv
// Shared types for the slotted ring: packet and injection-entry layouts plus
// the width derivations every stop must agree on.
package ring_pkg;

    localparam int RING_NUM_NODES = 4;
    localparam int RING_DATA_W    = 32;
    localparam int RING_MAX_LAPS  = 3;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int ID_W  = clog2_min1(RING_NUM_NODES);
    localparam int LAP_W = clog2_min1(RING_MAX_LAPS + 1);

    typedef struct packed {
        logic [ID_W-1:0]        src;
        logic [ID_W-1:0]        dest;
        logic [LAP_W-1:0]       laps;
        logic [RING_DATA_W-1:0] data;
    } pkt_t;

    typedef struct packed {
        logic [ID_W-1:0]        dest;
        logic [RING_DATA_W-1:0] data;
    } inj_entry_t;

endpackage

// File: rtl/ring_inj_fifo.sv
// Synchronous FIFO buffering core-injected packets until a ring slot frees up.
module ring_inj_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push && !full, pop && !empty})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ring_stop_router.sv
// One stop of the unidirectional slotted ring: ejects packets for this node,
// recirculates or drops those the core refuses, and fills empty slots from the FIFO.
module ring_stop_router
    import ring_pkg::*;
#(
    parameter int NUM_NODES    = RING_NUM_NODES,
    parameter int NODE_ID      = 0,
    parameter int DATA_WIDTH   = RING_DATA_W,
    parameter int INJ_DEPTH    = 4,
    parameter int MAX_LAPS     = RING_MAX_LAPS,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ring_in_valid,
    input  pkt_t                  ring_in_pkt,
    output logic                  ring_out_valid,
    output pkt_t                  ring_out_pkt,
    input  logic                  inj_valid,
    input  logic [ID_W-1:0]       inj_dest,
    input  logic [DATA_WIDTH-1:0] inj_data,
    output logic                  inj_ready,
    output logic                  ej_valid,
    output pkt_t                  ej_pkt,
    input  logic                  ej_ready,
    output logic                  starve,
    output logic                  drop_pulse,
    output logic                  err_dest
);

    localparam int CNT_W = $clog2(INJ_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ID_W-1:0]  MY_ID   = ID_W'(NODE_ID);
    localparam logic [LAP_W-1:0] LAP_MAX = LAP_W'(MAX_LAPS);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    inj_entry_t       push_entry;
    inj_entry_t       head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic             ej_free;
    logic             for_me;
    logic             capture;
    logic             drop;
    logic             fwd;
    logic             head_bad;
    pkt_t             fwd_pkt;
    pkt_t             inj_pkt;
    logic [STV_W-1:0] starve_cnt;

    // Both handshakes transfer on valid && ready at a rising edge; valid never
    // depends combinationally on ready, and the offered data holds until taken.
    assign inj_ready  = (fifo_count != CNT_W'(INJ_DEPTH));
    assign fifo_push  = inj_valid && !fifo_full;
    assign push_entry = '{dest: inj_dest, data: inj_data};
    assign starve     = (starve_cnt >= STV_MAX);

    ring_inj_fifo #(
        .WIDTH ($bits(inj_entry_t)),
        .DEPTH (INJ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        ej_free  = !ej_valid || ej_ready;
        for_me   = ring_in_valid && (ring_in_pkt.dest == MY_ID);
        capture  = for_me && ej_free;
        drop     = for_me && !ej_free && (ring_in_pkt.laps == LAP_MAX);
        fwd      = ring_in_valid && !capture && !drop;
        fwd_pkt  = ring_in_pkt;
        if (for_me) begin
            fwd_pkt.laps = ring_in_pkt.laps + LAP_W'(1);
        end
        // Ring traffic owns the slot; the FIFO only gets what is left over.
        fifo_pop = !fwd && !fifo_empty;
        head_bad = (32'(head.dest) >= NUM_NODES);
        inj_pkt  = '{src: MY_ID, dest: head.dest, laps: '0, data: head.data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_out_valid <= 1'b0;
            ring_out_pkt   <= '0;
            ej_valid       <= 1'b0;
            ej_pkt         <= '0;
            drop_pulse     <= 1'b0;
            err_dest       <= 1'b0;
            starve_cnt     <= '0;
        end else begin
            drop_pulse <= drop;

            if (fwd) begin
                ring_out_valid <= 1'b1;
                ring_out_pkt   <= fwd_pkt;
            end else if (fifo_pop && !head_bad) begin
                ring_out_valid <= 1'b1;
                ring_out_pkt   <= inj_pkt;
            end else begin
                ring_out_valid <= 1'b0;
            end

            if (capture) begin
                ej_valid <= 1'b1;
                ej_pkt   <= ring_in_pkt;
            end else if (ej_ready) begin
                ej_valid <= 1'b0;
            end

            if (fifo_pop && head_bad) begin
                err_dest <= 1'b1;
            end

            if (fifo_empty || fifo_pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STV_MAX) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ring_stop_router.sv
// Directed bench for ring_stop_router: a lone stop driven by hand, a 3-node stop
// for bad destinations, and a 4-stop ring exchanging all-to-all traffic.
module tb_ring_stop_router;
    import ring_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- single stop, NODE_ID=1 ----------------
    logic        ri_valid;
    pkt_t        ri_pkt;
    logic        ro_valid;
    pkt_t        ro_pkt;
    logic        inj_valid;
    logic [ID_W-1:0] inj_dest;
    logic [31:0] inj_data;
    logic        inj_ready;
    logic        ej_valid;
    pkt_t        ej_pkt;
    logic        ej_ready;
    logic        starve;
    logic        drop_pulse;
    logic        err_dest;

    ring_stop_router #(.NUM_NODES(4), .NODE_ID(1)) u_dut (
        .clk(clk), .rst(rst),
        .ring_in_valid(ri_valid), .ring_in_pkt(ri_pkt),
        .ring_out_valid(ro_valid), .ring_out_pkt(ro_pkt),
        .inj_valid(inj_valid), .inj_dest(inj_dest), .inj_data(inj_data), .inj_ready(inj_ready),
        .ej_valid(ej_valid), .ej_pkt(ej_pkt), .ej_ready(ej_ready),
        .starve(starve), .drop_pulse(drop_pulse), .err_dest(err_dest)
    );

    // ---------------- 3-node stop for out-of-range destinations ----------------
    logic        e_inj_valid;
    logic [ID_W-1:0] e_inj_dest;
    logic [31:0] e_inj_data;
    logic        e_inj_ready;
    logic        e_ro_valid;
    pkt_t        e_ro_pkt;
    logic        e_ej_valid;
    pkt_t        e_ej_pkt;
    logic        e_starve;
    logic        e_drop;
    logic        e_err;
    logic        e_ri_valid;
    pkt_t        e_ri_pkt;
    logic        e_ej_ready;

    ring_stop_router #(.NUM_NODES(3), .NODE_ID(0)) u_err (
        .clk(clk), .rst(rst),
        .ring_in_valid(e_ri_valid), .ring_in_pkt(e_ri_pkt),
        .ring_out_valid(e_ro_valid), .ring_out_pkt(e_ro_pkt),
        .inj_valid(e_inj_valid), .inj_dest(e_inj_dest), .inj_data(e_inj_data), .inj_ready(e_inj_ready),
        .ej_valid(e_ej_valid), .ej_pkt(e_ej_pkt), .ej_ready(e_ej_ready),
        .starve(e_starve), .drop_pulse(e_drop), .err_dest(e_err)
    );

    // ---------------- 4-stop ring ----------------
    logic            rg_valid     [4];
    pkt_t            rg_pkt       [4];
    logic            rg_inj_valid [4];
    logic [ID_W-1:0] rg_inj_dest  [4];
    logic [31:0]     rg_inj_data  [4];
    logic            rg_inj_ready [4];
    logic            rg_ej_valid  [4];
    pkt_t            rg_ej_pkt    [4];
    logic            rg_ej_ready  [4];
    logic            rg_starve    [4];
    logic            rg_drop      [4];
    logic            rg_err       [4];

    for (genvar g = 0; g < 4; g++) begin : g_ring
        ring_stop_router #(.NUM_NODES(4), .NODE_ID(g)) u_stop (
            .clk(clk), .rst(rst),
            .ring_in_valid(rg_valid[(g + 3) % 4]), .ring_in_pkt(rg_pkt[(g + 3) % 4]),
            .ring_out_valid(rg_valid[g]), .ring_out_pkt(rg_pkt[g]),
            .inj_valid(rg_inj_valid[g]), .inj_dest(rg_inj_dest[g]), .inj_data(rg_inj_data[g]),
            .inj_ready(rg_inj_ready[g]),
            .ej_valid(rg_ej_valid[g]), .ej_pkt(rg_ej_pkt[g]), .ej_ready(rg_ej_ready[g]),
            .starve(rg_starve[g]), .drop_pulse(rg_drop[g]), .err_dest(rg_err[g])
        );
    end

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t mk(input int s, input int d, input int l, input logic [31:0] data);
        pkt_t p;
        p.src  = ID_W'(s);
        p.dest = ID_W'(d);
        p.laps = LAP_W'(l);
        p.data = data;
        return p;
    endfunction

    task automatic drive_ring(input logic v, input pkt_t p);
        ri_valid = v;
        ri_pkt   = p;
    endtask

    task automatic drive_inj(input logic v, input int d, input logic [31:0] data);
        inj_valid = v;
        inj_dest  = ID_W'(d);
        inj_data  = data;
    endtask

    // ---------------- scoreboard for the ring ----------------
    logic [63:0] exp_q[$];

    task automatic deliver(input int node, input pkt_t p);
        bit found;
        found = 1'b0;
        check("ring_ej_dest", 64'(p.dest), 64'(node));
        check("ring_ej_src", 64'(p.src), 64'(p.data[7:4]));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (!found && exp_q[i] == 64'(p.data)) begin
                exp_q.delete(i);
                found = 1'b1;
            end
        end
        check("ring_ej_unique", 64'(found), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sent [4];
        int got;
        int drops;
        int cyc;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive_ring(1'b0, '0);
        drive_inj(1'b0, 0, '0);
        ej_ready = 1'b1;
        e_inj_valid = 1'b0; e_inj_dest = '0; e_inj_data = '0;
        e_ri_valid = 1'b0;  e_ri_pkt = '0;  e_ej_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            rg_inj_valid[n] = 1'b0; rg_inj_dest[n] = '0; rg_inj_data[n] = '0;
            rg_ej_ready[n] = 1'b0;  sent[n] = 0;
        end
        step();
        step();
        check("rst_ro_valid", 64'(ro_valid), 64'd0);
        check("rst_ej_valid", 64'(ej_valid), 64'd0);
        check("rst_inj_ready", 64'(inj_ready), 64'd1);
        check("rst_starve", 64'(starve), 64'd0);
        rst = 1'b0;

        // T2: injection onto an idle ring
        drive_inj(1'b1, 3, 32'hA5A5);
        step();
        drive_inj(1'b0, 0, '0);
        check("t2_not_yet", 64'(ro_valid), 64'd0);
        step();
        check("t2_ro_valid", 64'(ro_valid), 64'd1);
        check("t2_ro_pkt", 64'(ro_pkt), 64'(mk(1, 3, 0, 32'hA5A5)));
        step();
        check("t2_ro_idle", 64'(ro_valid), 64'd0);

        // T3a: eject into a free slot, empty FIFO leaves the slot empty
        drive_ring(1'b1, mk(2, 1, 0, 32'hC0DE));
        step();
        drive_ring(1'b0, '0);
        check("t3_ej_valid", 64'(ej_valid), 64'd1);
        check("t3_ej_pkt", 64'(ej_pkt), 64'(mk(2, 1, 0, 32'hC0DE)));
        check("t3_ro_empty", 64'(ro_valid), 64'd0);
        step();
        check("t3_ej_popped", 64'(ej_valid), 64'd0);

        // T3b: foreign packet forwarded while a push lands; then eject frees slot for FIFO head
        drive_ring(1'b1, mk(0, 3, 0, 32'hBEEF));
        drive_inj(1'b1, 2, 32'h11);
        step();
        drive_inj(1'b0, 0, '0);
        check("t3_fwd_valid", 64'(ro_valid), 64'd1);
        check("t3_fwd_pkt", 64'(ro_pkt), 64'(mk(0, 3, 0, 32'hBEEF)));
        drive_ring(1'b1, mk(3, 1, 1, 32'hF00D));
        step();
        drive_ring(1'b0, '0);
        check("t3_ej2_pkt", 64'(ej_pkt), 64'(mk(3, 1, 1, 32'hF00D)));
        check("t3_inj_valid", 64'(ro_valid), 64'd1);
        check("t3_inj_pkt", 64'(ro_pkt), 64'(mk(1, 2, 0, 32'h11)));
        step();

        // T4: core stalled -> recirculate with lap+1, drop at lap limit
        ej_ready = 1'b0;
        drive_ring(1'b1, mk(2, 1, 0, 32'hAA));
        step();
        check("t4_hold", 64'(ej_valid), 64'd1);
        drive_ring(1'b1, mk(2, 1, 0, 32'hBB));
        step();
        check("t4_recirc_valid", 64'(ro_valid), 64'd1);
        check("t4_recirc_pkt", 64'(ro_pkt), 64'(mk(2, 1, 1, 32'hBB)));
        check("t4_no_drop", 64'(drop_pulse), 64'd0);
        drive_ring(1'b1, mk(0, 1, 3, 32'hCC));
        step();
        drive_ring(1'b0, '0);
        check("t4_drop", 64'(drop_pulse), 64'd1);
        check("t4_drop_ro", 64'(ro_valid), 64'd0);
        step();
        check("t4_drop_once", 64'(drop_pulse), 64'd0);
        check("t4_ej_kept", 64'(ej_pkt), 64'(mk(2, 1, 0, 32'hAA)));
        ej_ready = 1'b1;
        step();
        check("t4_ej_release", 64'(ej_valid), 64'd0);

        // T5: busy ring fills FIFO and starves injection
        drive_ring(1'b1, mk(2, 3, 0, 32'hDD));
        for (int i = 0; i < 4; i++) begin
            drive_inj(1'b1, 0, 32'h100 + 32'(i));
            step();
        end
        drive_inj(1'b0, 0, '0);
        check("t5_full", 64'(inj_ready), 64'd0);
        for (int i = 0; i < 12; i++) step();
        check("t5_starve_15", 64'(starve), 64'd0);
        step();
        check("t5_starve_16", 64'(starve), 64'd1);
        step();
        step();
        check("t5_starve_sat", 64'(starve), 64'd1);
        drive_ring(1'b0, '0);
        step();
        check("t5_pop_starve", 64'(starve), 64'd0);
        check("t5_pop_ready", 64'(inj_ready), 64'd1);
        check("t5_pop_pkt", 64'(ro_pkt), 64'(mk(1, 0, 0, 32'h100)));
        for (int i = 1; i < 4; i++) begin
            step();
            check("t5_drain_pkt", 64'(ro_pkt), 64'(mk(1, 0, 0, 32'h100 + 32'(i))));
        end
        step();
        check("t5_drained", 64'(ro_valid), 64'd0);

        // T1: reset in the middle of traffic
        ej_ready = 1'b0;
        drive_ring(1'b1, mk(2, 1, 0, 32'h55));
        drive_inj(1'b1, 2, 32'h66);
        step();
        drive_ring(1'b1, mk(2, 3, 0, 32'h77));
        step();
        rst = 1'b1;
        step();
        step();
        check("t1_ro_valid", 64'(ro_valid), 64'd0);
        check("t1_ro_pkt", 64'(ro_pkt), 64'd0);
        check("t1_ej_valid", 64'(ej_valid), 64'd0);
        check("t1_ej_pkt", 64'(ej_pkt), 64'd0);
        check("t1_drop", 64'(drop_pulse), 64'd0);
        check("t1_err", 64'(err_dest), 64'd0);
        drive_ring(1'b0, '0);
        drive_inj(1'b0, 0, '0);
        ej_ready = 1'b1;
        rst = 1'b0;
        step();
        check("t1_fifo_empty_ro", 64'(ro_valid), 64'd0);
        check("t1_inj_ready", 64'(inj_ready), 64'd1);

        // Bad destination on a 3-node ring: dest 3 is out of range
        e_inj_valid = 1'b1; e_inj_dest = ID_W'(3); e_inj_data = 32'h99;
        step();
        e_inj_valid = 1'b0;
        step();
        check("err_set", 64'(e_err), 64'd1);
        check("err_no_ring", 64'(e_ro_valid), 64'd0);
        e_inj_valid = 1'b1; e_inj_dest = ID_W'(2); e_inj_data = 32'h77;
        step();
        e_inj_valid = 1'b0;
        step();
        check("err_good_pkt", 64'(e_ro_pkt), 64'(mk(0, 2, 0, 32'h77)));
        step();
        check("err_sticky", 64'(e_err), 64'd1);

        // T6: all-to-all over the 4-stop ring, random core backpressure
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 3; k++)
                exp_q.push_back(64'(s * 16 + (s + 1 + k) % 4));
        got = 0;
        drops = 0;
        cyc = 0;
        while (got + drops < 12 && cyc < 3000) begin
            for (int n = 0; n < 4; n++) begin
                rg_ej_ready[n]  = 1'($urandom_range(0, 1));
                rg_inj_valid[n] = (sent[n] < 3) && rg_inj_ready[n];
                rg_inj_dest[n]  = ID_W'((n + 1 + sent[n]) % 4);
                rg_inj_data[n]  = 32'(n * 16 + (n + 1 + sent[n]) % 4);
            end
            for (int n = 0; n < 4; n++) begin
                if (rg_ej_valid[n] && rg_ej_ready[n]) begin
                    deliver(n, rg_ej_pkt[n]);
                    got++;
                end
                if (rg_inj_valid[n]) sent[n]++;
            end
            step();
            for (int n = 0; n < 4; n++) begin
                if (rg_drop[n]) drops++;
            end
            cyc++;
        end
        for (int n = 0; n < 4; n++) rg_inj_valid[n] = 1'b0;
        check("t6_resolved", 64'(got + drops), 64'd12);
        check("t6_missing_eq_drops", 64'(exp_q.size()), 64'(drops));
        check("t6_no_err", 64'({rg_err[0], rg_err[1], rg_err[2], rg_err[3]}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
